// File: rtl/fetch_unit.sv
// Instruction fetch initiator: drives word-aligned fetch addresses, captures the
// 1-cycle registered memory response into a 2-entry FIFO, and hands it to decode.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               areset,
  output logic [ADDR_W-1:0]  o_req_addr,
  output logic               o_req_valid,
  input  logic [INSTR_W-1:0] i_res_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_instr_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_addr
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic [INSTR_W-1:0] fifo_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [BUF_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               deq;
  logic               issue;
  logic               wr;
  logic [2:0]         credit;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_addr[1:0];

  // Credits: buffered + in-flight after this cycle's dequeue must leave room
  // for the fetch we are about to issue, so the FIFO can never overflow.
  always_comb begin
    deq    = (count != 2'd0) && i_instr_ready;
    credit = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    issue  = !areset && !i_redirect && (credit < 3'd2);
    wr     = inflight && !i_redirect;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (i_redirect) begin
      // Redirect squashes the in-flight response and empties the FIFO.
      pc       <= {i_redirect_addr[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= '0;
    end else begin
      assert (!(wr && count == 2'd2));
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(4);
        inflight_pc <= pc;
      end
      if (wr) begin
        fifo_instr[wr_ptr] <= i_res_data;
        fifo_pc[wr_ptr]    <= inflight_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, wr} - {1'b0, deq};
    end
  end

  always_comb begin
    o_req_addr    = pc;
    o_req_valid   = issue;
    o_instr_valid = (count != 2'd0);
    o_instr       = fifo_instr[rd_ptr];
    o_instr_pc    = fifo_pc[rd_ptr];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes the expected decode stream on
// each (re)start, a negedge monitor checks fetch addresses, issue and handshakes.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          BATCH  = 64;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] o_req_addr;
  logic        o_req_valid;
  logic [31:0] i_res_data = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_addr = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  int          outstanding;
  int          avail;
  logic        prev_issue;
  int          since;

  fetch_unit #(
    .ADDR_W(32),
    .INSTR_W(32),
    .RESET_PC(RST_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clk(clk),
    .areset(areset),
    .o_req_addr(o_req_addr),
    .o_req_valid(o_req_valid),
    .i_res_data(i_res_data),
    .o_instr_valid(o_instr_valid),
    .o_instr(o_instr),
    .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready),
    .i_redirect(i_redirect),
    .i_redirect_addr(i_redirect_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h100 + {2'b00, a[31:2]};
  endfunction

  // Instruction memory: registered 1-cycle read, no handshake.
  always @(posedge clk) i_res_data <= word(o_req_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_q(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < BATCH; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Monitor / reference model: a fetch stream restarts at reset or redirect,
  // at most 2 fetches may be unconsumed, data shows up 2 cycles after issue.
  always @(negedge clk) begin
    logic deq;
    logic exp_issue;
    logic [31:0] p;
    if (areset) begin
      exp_addr    = RST_PC;
      outstanding = 0;
      avail       = 0;
      prev_issue  = 1'b0;
    end else begin
      deq       = o_instr_valid && i_instr_ready;
      exp_issue = !i_redirect && ((outstanding - int'(deq)) < 2);
      check("req_addr", 64'(o_req_addr), 64'(exp_addr));
      check("req_valid", 64'(o_req_valid), 64'(exp_issue));
      check("instr_valid", 64'(o_instr_valid), 64'(avail > 0));
      if (deq) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got pc 0x%0h expected none", o_instr_pc);
        end else begin
          p = exp_q.pop_front();
          check("instr_pc", 64'(o_instr_pc), 64'(p));
          check("instr_data", 64'(o_instr), 64'(word(p)));
        end
      end
      if (i_redirect) begin
        exp_addr    = {i_redirect_addr[31:2], 2'b00};
        outstanding = 0;
        avail       = 0;
        prev_issue  = 1'b0;
      end else begin
        avail       = avail + int'(prev_issue) - int'(deq);
        outstanding = outstanding + int'(exp_issue) - int'(deq);
        if (exp_issue) exp_addr = exp_addr + 32'd4;
        prev_issue  = exp_issue;
      end
    end
  end

  task automatic step(input logic rdy, input logic redir, input logic [31:0] addr);
    i_instr_ready   = rdy;
    i_redirect      = redir;
    i_redirect_addr = addr;
    @(posedge clk);
    if (redir) begin
      load_q({addr[31:2], 2'b00});
      since = 0;
    end else begin
      since++;
    end
    #1;
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic reset_mid(input int cycles);
    #1;
    areset     = 1'b1;
    i_redirect = 1'b0;
    #1;
    check("rst_req_valid", 64'(o_req_valid), 64'd0);
    check("rst_instr_valid", 64'(o_instr_valid), 64'd0);
    check("rst_instr", 64'(o_instr), 64'd0);
    check("rst_instr_pc", 64'(o_instr_pc), 64'd0);
    check("rst_req_addr", 64'(o_req_addr), 64'(RST_PC));
    load_q(RST_PC);
    since = 0;
    repeat (cycles) @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    since  = 0;
    load_q(RST_PC);
    #2;
    check("init_req_addr", 64'(o_req_addr), 64'(RST_PC));
    check("init_instr_valid", 64'(o_instr_valid), 64'd0);
    check("init_req_valid", 64'(o_req_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;

    // Streaming, then backpressure, then release.
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (5) step(1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, '0);

    // Redirect with a full FIFO and decode stalled.
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h40);
    repeat (4) step(1'b0, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, '0);

    // Misaligned redirect target.
    step(1'b1, 1'b1, 32'h43);
    repeat (5) step(1'b1, 1'b0, '0);

    // Back-to-back redirects, handshake during the first.
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b1, 32'hC0);
    repeat (6) step(1'b1, 1'b0, '0);

    // Reset while streaming with a fetch in flight.
    reset_mid(2);
    repeat (6) step(1'b1, 1'b0, '0);

    // PC wraparound.
    step(1'b1, 1'b1, 32'hFFFF_FFF4);
    repeat (8) step(1'b1, 1'b0, '0);

    // Randomized traffic.
    repeat (800) begin
      int r;
      logic rdy;
      logic [31:0] a;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE0 | (a & 32'h1F);
      if (r < 2) begin
        reset_mid(int'($urandom_range(1, 3)));
      end else if (r < 12 || since > 50) begin
        step(rdy, 1'b1, a);
      end else begin
        step(rdy, 1'b0, '0);
      end
    end

    repeat (4) step(1'b1, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
